// File: rtl/fifo_pack_reader_if.sv
// ---------------------------------------------------------------------------
// fifo_pack_reader_if
//   Bundles the FIFO read port, the flush request and the packed output
//   stream of fifo_pack_reader.
//   master : the packing reader (drives fifo_rd_en_o and the m_* stream)
//   slave  : the environment (FIFO + downstream consumer)
//   Signals:
//     fifo_empty_i  FIFO empty flag
//     fifo_rd_en_o  FIFO read strobe
//     fifo_dout_i   FIFO read data, valid the cycle after a strobe
//     flush_i       level request to emit a partially filled word
//     m_data_o      packed word, lane k = bits [k*WIDTH +: WIDTH]
//     m_cnt_o       number of valid lanes in m_data_o
//     m_valid_o     output word valid
//     m_ready_i     downstream accept
//     busy_o        any data held or in flight
// ---------------------------------------------------------------------------
interface fifo_pack_reader_if #(
    parameter int WIDTH = 8,
    parameter int RATIO = 4
);
    localparam int CNT_W = $clog2(RATIO) + 1;

    logic                     fifo_empty_i;
    logic                     fifo_rd_en_o;
    logic [WIDTH-1:0]         fifo_dout_i;
    logic                     flush_i;
    logic [WIDTH*RATIO-1:0]   m_data_o;
    logic [CNT_W-1:0]         m_cnt_o;
    logic                     m_valid_o;
    logic                     m_ready_i;
    logic                     busy_o;

    modport master (
        input  fifo_empty_i, fifo_dout_i, flush_i, m_ready_i,
        output fifo_rd_en_o, m_data_o, m_cnt_o, m_valid_o, busy_o
    );

    modport slave (
        output fifo_empty_i, fifo_dout_i, flush_i, m_ready_i,
        input  fifo_rd_en_o, m_data_o, m_cnt_o, m_valid_o, busy_o
    );
endinterface

// File: rtl/fifo_pack_reader.sv
// ---------------------------------------------------------------------------
// fifo_pack_reader
//   Pops narrow words from a synchronous FIFO with a registered read port
//   (data arrives the cycle after the strobe), packs RATIO of them LSB-first
//   into one wide word and offers it through a 2-entry output buffer on a
//   valid/ready stream. A flush request emits a partially filled word with
//   its lane count; unused lanes read as zero.
//   Ports:
//     clk_i      clock, rising edge
//     reset_n_i  asynchronous active-low reset
//     bus        fifo_pack_reader_if.master (FIFO port, flush, output stream)
// ---------------------------------------------------------------------------
module fifo_pack_reader #(
    parameter int WIDTH = 8,
    parameter int RATIO = 4
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    fifo_pack_reader_if.master bus
);
    localparam int OUT_W  = WIDTH * RATIO;
    localparam int CNT_W  = $clog2(RATIO) + 1;
    localparam int LANE_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int OCC_W  = $clog2(3 * RATIO + 1) + 1;

    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(RATIO);
    localparam logic [OCC_W-1:0]  RATIO_OCC = OCC_W'(RATIO);

    // State
    logic                 inflight_reg;
    logic [LANE_W-1:0]    pack_cnt_reg;
    logic [OUT_W-1:0]     pack_reg;
    logic [OUT_W-1:0]     buf_data_reg [2];
    logic [CNT_W-1:0]     buf_cnt_reg  [2];
    logic [1:0]           out_count_reg;

    // Combinational helpers
    logic                 buf_pop;
    logic                 buf_push;
    logic                 full_push;
    logic                 flush_push;
    logic                 rd_en;
    logic [OCC_W-1:0]     occ;
    logic [OCC_W-1:0]     occ_limit;
    logic [OUT_W-1:0]     cap_word;
    logic [OUT_W-1:0]     push_data;
    logic [CNT_W-1:0]     push_cnt;
    logic [1:0]           count_after_pop;
    logic [1:0]           out_count_next;
    logic [OUT_W-1:0]     buf_data_next [2];
    logic [CNT_W-1:0]     buf_cnt_next  [2];

    assign buf_pop = (out_count_reg != 2'd0) && bus.m_ready_i;

    // Occupancy counts every narrow word we have committed to hold: buffered
    // entries are charged a full RATIO even when they carry a partial word,
    // which keeps the bound conservative. The pop credit lets a read issue in
    // the same cycle a word leaves, so a ready stream runs without bubbles.
    assign occ       = OCC_W'(out_count_reg) * RATIO_OCC
                     + OCC_W'(pack_cnt_reg) + OCC_W'(inflight_reg);
    assign occ_limit = (RATIO_OCC << 1) + (buf_pop ? RATIO_OCC : '0);

    // Gated by reset_n_i so the strobe is low throughout reset.
    assign rd_en = reset_n_i && !bus.fifo_empty_i && !bus.flush_i
                   && (occ < occ_limit);
    assign bus.fifo_rd_en_o = rd_en;

    // Pack register with the returning FIFO word merged into lane pack_cnt.
    generate
        for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
            assign cap_word[gi*WIDTH +: WIDTH] =
                (inflight_reg && (pack_cnt_reg == LANE_W'(gi)))
                    ? bus.fifo_dout_i
                    : pack_reg[gi*WIDTH +: WIDTH];
        end
    endgenerate

    assign full_push  = inflight_reg && (pack_cnt_reg == LAST_LANE);
    // A partial word only leaves once nothing is still on its way from the
    // FIFO, otherwise that word would land in a freshly cleared register.
    assign flush_push = bus.flush_i && !inflight_reg && (pack_cnt_reg != '0)
                        && ((out_count_reg != 2'd2) || buf_pop);
    assign buf_push   = full_push || flush_push;
    assign push_data  = full_push ? cap_word : pack_reg;
    assign push_cnt   = full_push ? FULL_CNT : CNT_W'(pack_cnt_reg);

    // Output buffer kept head-at-index-0: a pop shifts entry 1 down, and a
    // push lands just behind whatever remains after the pop.
    always_comb begin
        buf_data_next   = buf_data_reg;
        buf_cnt_next    = buf_cnt_reg;
        count_after_pop = out_count_reg - {1'b0, buf_pop};
        if (buf_pop) begin
            buf_data_next[0] = buf_data_reg[1];
            buf_cnt_next[0]  = buf_cnt_reg[1];
        end
        if (buf_push) begin
            buf_data_next[count_after_pop[0]] = push_data;
            buf_cnt_next[count_after_pop[0]]  = push_cnt;
        end
        out_count_next = count_after_pop + {1'b0, buf_push};
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            inflight_reg    <= 1'b0;
            pack_cnt_reg    <= '0;
            pack_reg        <= '0;
            buf_data_reg[0] <= '0;
            buf_data_reg[1] <= '0;
            buf_cnt_reg[0]  <= '0;
            buf_cnt_reg[1]  <= '0;
            out_count_reg   <= 2'd0;
        end else begin
            inflight_reg <= rd_en;
            if (full_push || flush_push) begin
                pack_reg     <= '0;
                pack_cnt_reg <= '0;
            end else if (inflight_reg) begin
                pack_reg     <= cap_word;
                pack_cnt_reg <= pack_cnt_reg + LANE_W'(1);
            end
            buf_data_reg  <= buf_data_next;
            buf_cnt_reg   <= buf_cnt_next;
            out_count_reg <= out_count_next;
        end
    end

    assign bus.m_data_o  = buf_data_reg[0];
    assign bus.m_cnt_o   = buf_cnt_reg[0];
    assign bus.m_valid_o = (out_count_reg != 2'd0);
    assign bus.busy_o    = inflight_reg || (pack_cnt_reg != '0)
                           || (out_count_reg != 2'd0);
endmodule

// File: doc/fifo_pack_reader.md
# fifo_pack_reader

Read-side consumer for the team's synchronous `fifo` in the Lease Cache memory-controller test harness. It pops narrow words from the FIFO's registered-output read port and handles the one-cycle read latency. It packs `RATIO` consecutive words LSB-first into one wide word and presents them on a valid/ready stream through a 2-entry output buffer. A flush request emits a partially filled word with a count of its valid lanes.

## Interface
- `WIDTH`, 8: narrow FIFO word width.
- `RATIO`, 4: narrow words per output word; 1..16.
- `clk_i`  in  1: single clock; all logic on rising edge.
- `reset_n_i`  in  1: asynchronous, active-low reset.
- `fifo_empty_i`  in  1: FIFO empty flag.
- `fifo_rd_en_o`  out  1: FIFO read strobe.
- `fifo_dout_i`  in  WIDTH: FIFO read data, valid the cycle after a strobe.
- `flush_i`  in  1: level request to emit a partial word.
- `m_data_o`  out  WIDTH*RATIO: packed word; lane k = bits [k*WIDTH +: WIDTH].
- `m_cnt_o`  out  clog2(RATIO)+1: valid lanes in `m_data_o`, 1..RATIO.
- `m_valid_o`  out  1: output word valid.
- `m_ready_i`  in  1: downstream accepts; transfer when `m_valid_o && m_ready_i`.
- `busy_o`  out  1: any word in flight, in pack register or in output buffer.

## Operation
- State:
  - `inflight`: 1 bit; set the cycle after a strobe.
  - `pack_cnt`: 0..RATIO-1.
  - Pack register: WIDTH*RATIO bits.
  - Output buffer: 2 entries of {data, cnt} with `out_count` 0..2.
- Occupancy, in narrow units: `occ = out_count*RATIO + pack_cnt + inflight`.
- Pop credit: `pop_cr = RATIO` if (`m_valid_o && m_ready_i`), else 0.
- Read issue: `fifo_rd_en_o = !fifo_empty_i && !flush_i && (occ - pop_cr < 2*RATIO)`.
  - Combinational from `m_ready_i`, `fifo_empty_i` and `flush_i`.
  - Never asserted while `fifo_empty_i` = 1.
- Capture: when `inflight` = 1, `fifo_dout_i` is written to lane `pack_cnt` and `pack_cnt` increments.
  - If that lane is RATIO-1, the full word plus cnt=RATIO is pushed to the output buffer, `pack_cnt` returns to 0 and the pack register clears to 0.
- Flush: while `flush_i` = 1, no new reads are issued.
  - Once `inflight` = 0, `pack_cnt` > 0, and `out_count` < 2 (or a pop occurs this cycle), push {pack register, `pack_cnt`}.
  - Unused lanes are 0. `pack_cnt` goes to 0.
  - Flush with `pack_cnt` = 0 emits nothing.
- Output buffer: FIFO order. Push and pop in the same cycle are both honoured. `m_data_o`/`m_cnt_o` show the head entry.
- Overflow is impossible by construction. An internal push to a full buffer is a design error; the bench asserts on it.
- `busy_o = inflight || pack_cnt != 0 || out_count != 0`.

## Timing
- Reset (asynchronous assert, synchronous-to-clock release):
  - Zero: `fifo_rd_en_o`, `m_valid_o`, `m_data_o`, `m_cnt_o`, `busy_o`, `inflight`, `pack_cnt`, `out_count`, and the pack register.
  - Reset mid-operation discards all partial and buffered data. The FIFO is not rewound.
- Latency: strobe at cycle t, data captured at t+1.
  - The final lane captured at t+1 makes `m_valid_o` = 1 at t+2 if the buffer was empty.
- Throughput: with `m_ready_i` held high and the FIFO non-empty, one strobe every cycle, i.e. one output word every RATIO cycles with no bubbles.
- Backpressure: with `m_ready_i` held low, strobes stop once `occ` reaches 2*RATIO. No captured data is ever dropped.
- `m_data_o`/`m_cnt_o` stay stable while `m_valid_o && !m_ready_i`.
- `fifo_empty_i` rising in the same cycle as a strobe is not checked. The FIFO owns that check; this block only gates on the current flag.

## Test plan
- Reset, then FIFO holding 0x01..0x08, `m_ready_i` = 1:
  - 8 strobes on consecutive cycles.
  - Outputs 0x04030201 then 0x08070605, cnt=4.
  - First `m_valid_o` 2 cycles after the 4th strobe.
- `m_ready_i` = 0, FIFO holding 12 words:
  - Exactly 8 strobes, then `fifo_rd_en_o` stays 0 and `m_valid_o` = 1 holding 0x04030201.
  - Raising ready drains in order.
- FIFO holding 0xAA, 0xBB, 0xCC, then empty; pulse `flush_i` for 3 cycles:
  - Output 0x00CCBBAA, cnt=3.
  - `busy_o` falls the cycle after the transfer.
- `fifo_empty_i` toggling every cycle:
  - `fifo_rd_en_o` is never high while empty.
  - Data order is preserved across 64 random words versus a scoreboard.
- Assert `reset_n_i` low with an in-flight read and 2 buffered words:
  - All outputs are 0 immediately.
  - After release, the next 4 words pack correctly from lane 0.
- RATIO=1, WIDTH=16, random `m_ready_i`:
  - Output stream equals the input stream, cnt always 1.
  - Sustained 1 word per cycle while ready is held high.
